// File: rtl/sw_event_capture_if.sv
// rtl/sw_event_capture_if.sv - switch event stream: valid/ready handshake with index and level
interface sw_event_capture_if;
    logic       ev_valid;
    logic       ev_ready;
    logic [3:0] ev_idx;
    logic       ev_level;

    modport master (
        output ev_valid,
        output ev_idx,
        output ev_level,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_idx,
        input  ev_level,
        output ev_ready
    );
endinterface

// File: rtl/sw_event_capture.sv
// rtl/sw_event_capture.sv - 16-switch synchronize/debounce with queued change events
// Macro SW_EVENT_FIFO_EN: defined -> 4-entry event FIFO, undefined -> single holding register.
module sw_event_capture #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [15:0]         sw,
    output logic [15:0]         sw_level,
    output logic                busy,
    sw_event_capture_if.master  ev
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
`ifdef SW_EVENT_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    typedef logic [4:0] entry_t;

    logic [15:0]    s1_q, s2_q;
    logic [15:0]    level_q, level_d;
    logic [15:0]    pend_q, pend_d;
    logic [15:0]    commit;
    logic [CW-1:0]  cnt_q [16];
    logic [CW-1:0]  cnt_d [16];
    entry_t         qd_q [DEPTH];
    entry_t         qd_d [DEPTH];
    logic [DEPTH-1:0] qv_q, qv_d;
    logic           busy_q, busy_d;

    logic           pop, push, can_accept, placed;
    logic [3:0]     push_idx;
    entry_t         push_entry;

    // A counter only runs while the synchronized level disagrees with the accepted one.
    always_comb begin
        level_d = level_q;
        commit  = '0;
        for (int i = 0; i < 16; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    level_d[i] = s2_q[i];
                    commit[i]  = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Queue is kept head-aligned: entry 0 is always the head, free slots hold zero.
    always_comb begin
        pop        = qv_q[0] && ev.ev_ready;
        can_accept = !qv_q[DEPTH-1] || pop;

        push_idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (pend_q[i]) push_idx = 4'(i);
        end
        push       = (|pend_q) && can_accept;
        push_entry = {push_idx, level_q[push_idx]};

        qv_d = qv_q;
        qd_d = qd_q;
        if (pop) begin
            for (int k = 0; k < DEPTH - 1; k++) begin
                qv_d[k] = qv_q[k+1];
                qd_d[k] = qd_q[k+1];
            end
            qv_d[DEPTH-1] = 1'b0;
            qd_d[DEPTH-1] = '0;
        end

        placed = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (push && !placed && !qv_d[k]) begin
                qv_d[k] = 1'b1;
                qd_d[k] = push_entry;
                placed  = 1'b1;
            end
        end

        // A re-commit on the bit being pushed keeps it pending so the newer level is queued too.
        pend_d = pend_q;
        if (push) pend_d[push_idx] = 1'b0;
        pend_d = pend_d | commit;
        busy_d = |pend_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q    <= '0;
            s2_q    <= '0;
            level_q <= '0;
            pend_q  <= '0;
            busy_q  <= 1'b0;
            qv_q    <= '0;
            for (int i = 0; i < 16; i++) cnt_q[i] <= '0;
            for (int k = 0; k < DEPTH; k++) qd_q[k] <= '0;
        end else begin
            s1_q    <= sw;
            s2_q    <= s1_q;
            level_q <= level_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
            qv_q    <= qv_d;
            for (int i = 0; i < 16; i++) cnt_q[i] <= cnt_d[i];
            for (int k = 0; k < DEPTH; k++) qd_q[k] <= qd_d[k];
        end
    end

    assign sw_level    = level_q;
    assign busy        = busy_q;
    assign ev.ev_valid = qv_q[0];
    assign ev.ev_idx   = qd_q[0][4:1];
    assign ev.ev_level = qd_q[0][0];

endmodule

// File: tb/tb_sw_event_capture.sv
// tb/tb_sw_event_capture.sv - directed self-checking bench for sw_event_capture
module tb_sw_event_capture;

    logic        clk;
    logic        reset;
    logic [15:0] sw;
    logic [15:0] sw_level;
    logic        busy;
    int          n_tests;
    int          n_fail;

    sw_event_capture_if evif ();

    sw_event_capture #(.DEBOUNCE_CYCLES(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .sw       (sw),
        .sw_level (sw_level),
        .busy     (busy),
        .ev       (evif.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pop_one;
        evif.ev_ready = 1'b1;
        tick(1);
        evif.ev_ready = 1'b0;
    endtask

`ifdef SW_EVENT_FIFO_EN
    logic [3:0] exp_order [6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd8};
`endif

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        reset         = 1'b1;
        sw            = '0;
        evif.ev_ready = 1'b0;
        tick(2);
        check("rst_valid", evif.ev_valid, 0);
        check("rst_idx",   evif.ev_idx,   0);
        check("rst_level", evif.ev_level, 0);
        check("rst_busy",  busy,          0);
        check("rst_swlvl", sw_level,      0);

        // sw[5] rises before edge 1; event must appear after edge 7
        reset = 1'b0;
        sw    = 16'h0020;
        tick(5);
        check("rise_swlvl_e5", sw_level, 16'h0000);
        tick(1);
        check("rise_swlvl_e6", sw_level, 16'h0020);
        check("rise_busy_e6",  busy, 1);
        check("rise_valid_e6", evif.ev_valid, 0);
        tick(1);
        check("rise_valid_e7", evif.ev_valid, 1);
        check("rise_idx",      evif.ev_idx, 5);
        check("rise_level",    evif.ev_level, 1);
        check("rise_busy_e7",  busy, 0);
        tick(3);
        check("hold_valid", evif.ev_valid, 1);
        check("hold_idx",   evif.ev_idx, 5);
        pop_one();
        check("pop_valid", evif.ev_valid, 0);
        check("pop_idx",   evif.ev_idx, 0);

        // three-cycle glitch on sw[3] is rejected
        sw = 16'h0028;
        tick(3);
        sw = 16'h0020;
        tick(1);
        check("glitch_busy_mid", busy, 0);
        tick(10);
        check("glitch_swlvl", sw_level, 16'h0020);
        check("glitch_valid", evif.ev_valid, 0);
        check("glitch_busy",  busy, 0);

        // falling edge on sw[5]
        sw = 16'h0000;
        tick(7);
        check("fall_valid", evif.ev_valid, 1);
        check("fall_idx",   evif.ev_idx, 5);
        check("fall_level", evif.ev_level, 0);
        check("fall_swlvl", sw_level, 16'h0000);
        pop_one();

        // sw[0], sw[7], sw[15] together, drained on consecutive edges
        sw = 16'h8081;
        tick(10);
        check("multi_valid", evif.ev_valid, 1);
        check("multi_idx0",  evif.ev_idx, 0);
        evif.ev_ready = 1'b1;
        tick(1);
        check("multi_idx7",  evif.ev_idx, 7);
        check("multi_v7",    evif.ev_valid, 1);
        tick(1);
        check("multi_idx15", evif.ev_idx, 15);
        check("multi_lvl15", evif.ev_level, 1);
        tick(1);
        evif.ev_ready = 1'b0;
        check("multi_empty", evif.ev_valid, 0);
        check("multi_busy",  busy, 0);

`ifdef SW_EVENT_FIFO_EN
        // six switches at once: four queued, two pending
        sw = sw ^ 16'h015E;
        tick(12);
        check("six_valid", evif.ev_valid, 1);
        check("six_busy",  busy, 1);
        for (int k = 0; k < 6; k++) begin
            check("six_idx", evif.ev_idx, exp_order[k]);
            check("six_lvl", evif.ev_level, 1);
            pop_one();
        end
        check("six_empty", evif.ev_valid, 0);
        check("six_busy_end", busy, 0);
`else
        // single holding register: sw[9] waits behind sw[2]
        sw = sw ^ 16'h0204;
        tick(7);
        check("hold2_idx",   evif.ev_idx, 2);
        check("hold2_busy",  busy, 1);
        tick(3);
        check("hold2_idx_l", evif.ev_idx, 2);
        check("hold2_busy_l", busy, 1);
        pop_one();
        check("hold9_valid", evif.ev_valid, 1);
        check("hold9_idx",   evif.ev_idx, 9);
        check("hold9_level", evif.ev_level, 1);
        check("hold9_busy",  busy, 0);
        pop_one();
        check("hold_empty",  evif.ev_valid, 0);
`endif

        // reset mid-operation with an event presented and a commit pending
        sw = sw ^ 16'h0400;
        tick(7);
        check("pre_valid", evif.ev_valid, 1);
        check("pre_idx",   evif.ev_idx, 10);
        sw = sw ^ 16'h1000;
        tick(6);
        check("pre_busy",  busy, 1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_valid", evif.ev_valid, 0);
        check("mid_rst_busy",  busy, 0);
        check("mid_rst_swlvl", sw_level, 0);
        check("mid_rst_idx",   evif.ev_idx, 0);
        sw = 16'h0010;
        tick(2);

        // switch held high across reset release reports as a normal rise
        reset = 1'b0;
        tick(6);
        check("post_valid_e6", evif.ev_valid, 0);
        tick(1);
        check("post_valid_e7", evif.ev_valid, 1);
        check("post_idx",      evif.ev_idx, 4);
        check("post_level",    evif.ev_level, 1);
        check("post_swlvl",    sw_level, 16'h0010);
        pop_one();
        tick(4);
        check("post_empty",    evif.ev_valid, 0);
        check("post_busy",     busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
